// File: rtl/btn_route_pkg.sv
// Shared constants for the button routing controller: select width,
// button indices, default timing parameters and the select step helper.
package btn_route_pkg;

  localparam int SEL_W    = 2;
  localparam int NUM_BTNS = 5;

  // Positions of each push-button in the per-button vectors
  localparam int BTN_U = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_D = 3;
  localparam int BTN_C = 4;

  // 10 ms debounce and 1 s scan step at 100 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_SCAN_CYCLES     = 100_000_000;

  typedef logic [SEL_W-1:0] sel_t;

  // One wrap-around step: up alone +1, down alone -1, both or neither hold
  function automatic sel_t sel_step(input sel_t sel, input logic up, input logic dn);
    sel_t res;
    res = sel;
    if (up && !dn) begin
      res = sel + SEL_W'(1);
    end else if (dn && !up) begin
      res = sel - SEL_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioning: 2-flop synchroniser, debounce counter,
// accepted (stable) level and a one-cycle pulse on its rising edge.
module btn_debounce
  import btn_route_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             stable_reg;
  logic             stable_next;
  logic             stable_dly_reg;

  // Bring the raw button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], btn};
    end
  end

  // Count how long the synchronised level has disagreed with the accepted one
  always_comb begin
    cnt_next    = '0;
    stable_next = stable_reg;
    if (sync_reg[1] != stable_reg) begin
      if (cnt_reg == CNT_MAX) begin
        stable_next = sync_reg[1];
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Debounce state and the delayed copy used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      stable_reg     <= 1'b0;
      stable_dly_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      stable_reg     <= stable_next;
      stable_dly_reg <= stable_reg;
    end
  end

  // Only presses matter; releases are ignored
  assign press = stable_reg & ~stable_dly_reg;

endmodule

// File: rtl/btn_route_ctrl.sv
// Routing controller for the 4-to-1 source mux and 1-to-4 destination demux.
// Five debounced buttons step Sel / Sel_DeMux (wrap-around) and toggle Enable.
// Optional feature: define BTN_ROUTE_AUTOSCAN_EN to step both selects
// automatically every SCAN_CYCLES while Enable is high.
module btn_route_ctrl
  import btn_route_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SCAN_CYCLES     = DEFAULT_SCAN_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btnU,
  input  logic             btnL,
  input  logic             btnR,
  input  logic             btnD,
  input  logic             btnC,
  output logic [SEL_W-1:0] Sel,
  output logic [SEL_W-1:0] Sel_DeMux,
  output logic             Enable
);

  if (DEBOUNCE_CYCLES < 2 || SCAN_CYCLES < 2) begin : g_param_check
    $error("btn_route_ctrl: DEBOUNCE_CYCLES and SCAN_CYCLES must be at least 2");
  end

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] press;
  sel_t                sel_reg, sel_next;
  sel_t                dmx_reg, dmx_next;
  logic                enable_reg, enable_next;

  // Gather the buttons into an index-addressed vector
  always_comb begin
    btn_raw        = '0;
    btn_raw[BTN_U] = btnU;
    btn_raw[BTN_L] = btnL;
    btn_raw[BTN_R] = btnR;
    btn_raw[BTN_D] = btnD;
    btn_raw[BTN_C] = btnC;
  end

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_raw[gi]),
      .press(press[gi])
    );
  end

`ifdef BTN_ROUTE_AUTOSCAN_EN
  localparam int             SCAN_W   = $clog2(SCAN_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);

  logic [SCAN_W-1:0] scan_reg, scan_next;
  logic              manual_step;

  assign manual_step = press[BTN_U] | press[BTN_L] | press[BTN_R] | press[BTN_D];
`endif

  // Next routing state: manual presses first, then (optionally) the autoscan step
  always_comb begin
    sel_next    = sel_step(sel_reg, press[BTN_U], press[BTN_L]);
    dmx_next    = sel_step(dmx_reg, press[BTN_R], press[BTN_D]);
    enable_next = enable_reg ^ press[BTN_C];
`ifdef BTN_ROUTE_AUTOSCAN_EN
    scan_next = '0;
    // A manual step wins over a coincident scan step and restarts the period
    if (enable_reg && !manual_step) begin
      if (scan_reg == SCAN_MAX) begin
        sel_next = sel_reg + SEL_W'(1);
        dmx_next = dmx_reg + SEL_W'(1);
      end else begin
        scan_next = scan_reg + 1'b1;
      end
    end
`endif
  end

  // Output registers: no combinational path from the buttons to the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg    <= '0;
      dmx_reg    <= '0;
      enable_reg <= 1'b0;
    end else begin
      sel_reg    <= sel_next;
      dmx_reg    <= dmx_next;
      enable_reg <= enable_next;
    end
  end

`ifdef BTN_ROUTE_AUTOSCAN_EN
  // Scan period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_reg <= '0;
    end else begin
      scan_reg <= scan_next;
    end
  end
`endif

  assign Sel       = sel_reg;
  assign Sel_DeMux = dmx_reg;
  assign Enable    = enable_reg;

endmodule

// File: tb/tb_btn_route_ctrl.sv
// Directed bench for btn_route_ctrl with DEBOUNCE_CYCLES = 4, SCAN_CYCLES = 8.
// A button set just after edge K changes the outputs at edge K+7.
module tb_btn_route_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnU = 1'b0, btnL = 1'b0, btnR = 1'b0, btnD = 1'b0, btnC = 1'b0;
  logic [1:0] Sel, Sel_DeMux;
  logic       Enable;

  int n_checks = 0;
  int n_pass   = 0;

  btn_route_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SCAN_CYCLES    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btnU     (btnU),
    .btnL     (btnL),
    .btnR     (btnR),
    .btnD     (btnD),
    .btnC     (btnC),
    .Sel      (Sel),
    .Sel_DeMux(Sel_DeMux),
    .Enable   (Enable)
  );

  always #5 clk = ~clk;

  // Button vector order: {C, D, R, L, U}
  typedef struct {
    string      name;
    logic [4:0] btns;
    int         exp_sel;
    int         exp_dmx;
    int         exp_en;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_out(input string tag, input int s, input int d, input int e);
    check({tag, ".Sel"}, int'(Sel), s);
    check({tag, ".Sel_DeMux"}, int'(Sel_DeMux), d);
    check({tag, ".Enable"}, int'(Enable), e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btnC, btnD, btnR, btnL, btnU} = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ps, pd, pe;

    vecs[0]  = '{"U0", 5'b00001, 1, 0, 0};
    vecs[1]  = '{"U1", 5'b00001, 2, 0, 0};
    vecs[2]  = '{"U2", 5'b00001, 3, 0, 0};
    vecs[3]  = '{"U3", 5'b00001, 0, 0, 0};
    vecs[4]  = '{"U4", 5'b00001, 1, 0, 0};
    vecs[5]  = '{"L0", 5'b00010, 0, 0, 0};
    vecs[6]  = '{"L1", 5'b00010, 3, 0, 0};
    vecs[7]  = '{"R0", 5'b00100, 3, 1, 0};
    vecs[8]  = '{"D0", 5'b01000, 3, 0, 0};
    vecs[9]  = '{"D1", 5'b01000, 3, 3, 0};
    vecs[10] = '{"R1", 5'b00100, 3, 0, 0};

    // Reset state
    step(2);
    check_out("reset", 0, 0, 0);
    $display("reset: Sel=%0d Sel_DeMux=%0d Enable=%0d", Sel, Sel_DeMux, Enable);
    rst_n = 1'b1;
    step(2);

    // Single-button presses: wrap-around up/down on both selects
    ps = 0; pd = 0; pe = 0;
    for (int i = 0; i < 11; i++) begin
      set_btns(vecs[i].btns);
      step(6);
      check_out({vecs[i].name, ".early"}, ps, pd, pe);
      step(1);
      check_out(vecs[i].name, vecs[i].exp_sel, vecs[i].exp_dmx, vecs[i].exp_en);
      set_btns(5'b0);
      step(10);
      check_out({vecs[i].name, ".release"}, vecs[i].exp_sel, vecs[i].exp_dmx, vecs[i].exp_en);
      $display("vec %0d %s: Sel=%0d Sel_DeMux=%0d Enable=%0d", i, vecs[i].name, Sel, Sel_DeMux, Enable);
      ps = vecs[i].exp_sel; pd = vecs[i].exp_dmx; pe = vecs[i].exp_en;
    end

    // Asynchronous reset mid-debounce with btnU held
    btnU = 1'b1;
    step(3);
    #2 rst_n = 1'b0;
    #1 check_out("rst_async", 0, 0, 0);
    step(2);
    check_out("rst_held", 0, 0, 0);
    rst_n = 1'b1;
    step(6);
    check("rst_rel.early.Sel", int'(Sel), 0);
    step(1);
    check("rst_rel.Sel", int'(Sel), 1);
    step(20);
    check("rst_rel.hold.Sel", int'(Sel), 1);
    btnU = 1'b0;
    step(10);
    $display("reset-hold: Sel=%0d Sel_DeMux=%0d Enable=%0d", Sel, Sel_DeMux, Enable);

    // Bouncing btnR: short pulses rejected, final level accepted once
    for (int i = 0; i < 5; i++) begin
      btnR = 1'b1;
      step(2);
      btnR = 1'b0;
      step(2);
    end
    check("bounce.pulses.Sel_DeMux", int'(Sel_DeMux), 0);
    btnR = 1'b1;
    step(6);
    check("bounce.early.Sel_DeMux", int'(Sel_DeMux), 0);
    step(1);
    check("bounce.Sel_DeMux", int'(Sel_DeMux), 1);
    step(10);
    btnR = 1'b0;
    step(10);
    check("bounce.release.Sel_DeMux", int'(Sel_DeMux), 1);
    $display("bounce: Sel=%0d Sel_DeMux=%0d Enable=%0d", Sel, Sel_DeMux, Enable);

    // Simultaneous U+L, R and C on the same edge
    set_btns(5'b10111);
    step(6);
    check_out("simul.early", 1, 1, 0);
    step(1);
    check_out("simul", 1, 2, 1);
    set_btns(5'b0);
    $display("simultaneous: Sel=%0d Sel_DeMux=%0d Enable=%0d", Sel, Sel_DeMux, Enable);

`ifdef BTN_ROUTE_AUTOSCAN_EN
    // Enable rose at edge E (now E+1ns); scan steps at E+8, E+16, ...
    step(7);
    check_out("scan.e7", 1, 2, 1);
    step(1);
    check_out("scan.e8", 2, 3, 1);
    step(8);
    check_out("scan.e16", 3, 0, 1);
    step(1);
    btnD = 1'b1;
    step(6);
    check_out("scan.e23", 3, 0, 1);
    step(1);
    check_out("scan.e24_manual", 3, 3, 1);
    step(7);
    check_out("scan.e31", 3, 3, 1);
    step(1);
    check_out("scan.e32", 0, 0, 1);
    btnD = 1'b0;
    $display("autoscan: Sel=%0d Sel_DeMux=%0d Enable=%0d", Sel, Sel_DeMux, Enable);
`else
    step(10);
    check_out("simul.release", 1, 2, 1);
`endif

    // btnC held 50 cycles: one toggle, nothing on release
    btnC = 1'b1;
    step(6);
    check("holdC.early.Enable", int'(Enable), 1);
    step(1);
    check("holdC.Enable", int'(Enable), 0);
    step(43);
    check("holdC.held.Enable", int'(Enable), 0);
    btnC = 1'b0;
    step(10);
    check("holdC.release.Enable", int'(Enable), 0);
    $display("hold-C: Sel=%0d Sel_DeMux=%0d Enable=%0d", Sel, Sel_DeMux, Enable);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
